ddr_app_arbiter: RTL and testbench
==================================

// Module: ddr_app_arbiter
// PURPOSE
//   Round-robin arbiter sharing one MIG DDR4 native app-interface channel (cN_app_*) between
//   NUM_REQ user requesters inside the RP when AXI_DDR is not defined. One instance per channel.
//   Gates all traffic on init_calib_complete and routes in-order read returns to the issuer.
// PARAMETERS
//   NUM_REQ        4    number of requesters (2..8)
//   ADDR_W         28   app_addr width
//   DATA_W         512  app data width; mask width is DATA_W/8
//   TAG_DEPTH      32   read-tag FIFO depth (power of 2); max outstanding reads
// PORTS
//   pe_clk           in   1                  clock (cN_ddr4_ui_clk domain)
//   pe_clk_rst       in   1                  synchronous active-high reset
//   init_calib_complete in 1                 MIG calibration done
//   req_valid        in   NUM_REQ            per-requester command valid
//   req_ready        out  NUM_REQ            one-hot accept pulse
//   req_rd           in   NUM_REQ            1=read, 0=write
//   req_addr         in   NUM_REQ*ADDR_W     packed, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata        in   NUM_REQ*DATA_W     packed write data
//   req_wmask        in   NUM_REQ*DATA_W/8   packed write mask (1=byte masked off)
//   app_en/app_cmd   out  1/3                MIG command strobe / 3'b000 wr, 3'b001 rd
//   app_addr         out  ADDR_W             MIG address
//   app_rdy          in   1                  MIG command accept
//   app_wdf_wren/app_wdf_end out 1/1         write-data strobe / end (always equal)
//   app_wdf_data/app_wdf_mask out DATA_W/DATA_W/8
//   app_wdf_rdy      in   1                  MIG write-data accept
//   app_rd_data_valid in  1                  MIG read return strobe
//   app_rd_data      in   DATA_W             MIG read data
//   rsp_valid        out  NUM_REQ            one-hot read-return strobe (no backpressure)
//   rsp_data         out  DATA_W             read data, shared by all requesters
//   busy             out  1                  state!=ARB or tag FIFO non-empty
//   err_underflow    out  1                  sticky: read return with empty tag FIFO
// BEHAVIOUR
//   Reset: state=WAIT_CAL, rr_ptr=0, tag FIFO empty; all outputs 0 (app_cmd=0, data/addr=0).
//   FSM WAIT_CAL -> ARB when init_calib_complete=1. No grants in WAIT_CAL.
//   ARB: eligible(i)=req_valid[i] & (!req_rd[i] | !tag_full). Grant first eligible index
//     searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready[g]=1 for that cycle only (comb from
//     state/ptr/inputs); payload latched; rr_ptr<=g+1 mod NUM_REQ; -> ISSUE next cycle.
//     Write blocked by full tag FIFO is not; only reads are skipped. No eligible -> stay ARB.
//   ISSUE: app_en=1 and latched cmd/addr held until app_rdy=1 sampled. For writes,
//     app_wdf_wren=app_wdf_end=1 with data/mask held until app_wdf_rdy=1, independently; each
//     strobe drops the cycle after its own accept (cmd and data may accept in either order or
//     same cycle). Both accepted (read: cmd only) -> ARB. Min 2 cycles/command (ARB+ISSUE).
//   Read cmd accept (app_en&app_rdy&rd) pushes grant index into tag FIFO same edge.
//   app_rd_data_valid pops tag: next cycle rsp_valid[tag]=1, rsp_data=app_rd_data (1-cycle lat).
//     Simultaneous push and pop allowed, occupancy unchanged; pop on full FIFO legal.
//   Pop with FIFO empty: no rsp_valid, err_underflow<=1 until reset.
//   tag_full: occupancy==TAG_DEPTH; pointers wrap mod TAG_DEPTH with extra wrap bit.
//   init_calib_complete falling: in-flight ISSUE completes, then -> WAIT_CAL; returns still routed.
//   pe_clk_rst mid-operation: immediate return to reset state; outstanding tags discarded.
// TESTING
//   Reset, calib=0, all req_valid=1 -> no req_ready, app_en=0 for 20 cycles; calib=1 -> grant 0.
//   NUM_REQ=4 all valid writes, app_rdy=app_wdf_rdy=1 -> grant order 0,1,2,3,0; one cmd/2 cycles.
//   Write, app_rdy=1 at cycle 3, app_wdf_rdy=1 at cycle 6 -> app_en drops c4, wren drops c7, ARB c7.
//   Req1 reads 0x100, req3 reads 0x200; returns D0,D1 -> rsp_valid=4'b0010 D0 then 4'b1000 D1.
//   33 reads, no returns, TAG_DEPTH=32 -> 33rd read not granted, write from req2 granted meanwhile.
//   app_rd_data_valid with no outstanding read -> err_underflow=1, rsp_valid stays 0; reset clears.

Source files
------------

// File: rtl/ddr_app_arbiter.sv
// Round-robin arbiter sharing one MIG native app channel among NUM_REQ requesters.
// Read returns are routed back to their issuer through an in-order tag FIFO.
module ddr_app_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 32
) (
  input  logic                        pe_clk,
  input  logic                        pe_clk_rst,
  input  logic                        init_calib_complete,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_rd,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wmask,
  output logic                        app_en,
  output logic [2:0]                  app_cmd,
  output logic [ADDR_W-1:0]           app_addr,
  input  logic                        app_rdy,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [DATA_W-1:0]           app_wdf_data,
  output logic [DATA_W/8-1:0]         app_wdf_mask,
  input  logic                        app_wdf_rdy,
  input  logic                        app_rd_data_valid,
  input  logic [DATA_W-1:0]           app_rd_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic                        err_underflow
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MW = DATA_W / 8;
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {
    WAIT_CAL,
    ARB,
    ISSUE
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]     rr_ptr;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic              cmd_pend;
  logic              dat_pend;
  logic              lat_rd;
  logic [PW-1:0]     lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [MW-1:0]     lat_mask;

  logic [PW-1:0]     tag_mem [TAG_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              tag_full;
  logic              tag_empty;
  logic              push;
  logic              pop;
  logic [PW-1:0]     pop_tag;

  assign tag_empty = (wr_ptr == rd_ptr);
  assign tag_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = cmd_pend & app_rdy & lat_rd;
  assign pop       = app_rd_data_valid & ~tag_empty;
  assign pop_tag   = tag_mem[rd_ptr[AW-1:0]];

  // First eligible requester starting at rr_ptr; reads skipped when tags run out
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state == ARB && init_calib_complete) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!grant_vld && req_valid[idx] &&
            (!req_rd[idx] || !tag_full)) begin
          grant_vld = 1'b1;
          grant_idx = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_CAL: if (init_calib_complete) state_n = ARB;
      ARB: begin
        if (!init_calib_complete) state_n = WAIT_CAL;
        else if (grant_vld)       state_n = ISSUE;
      end
      ISSUE: begin
        if ((!cmd_pend || app_rdy) && (!dat_pend || app_wdf_rdy))
          state_n = init_calib_complete ? ARB : WAIT_CAL;
      end
      default: state_n = WAIT_CAL;
    endcase
  end

  always_ff @(posedge pe_clk) begin
    if (pe_clk_rst) begin
      state         <= WAIT_CAL;
      rr_ptr        <= '0;
      cmd_pend      <= 1'b0;
      dat_pend      <= 1'b0;
      lat_rd        <= 1'b0;
      lat_idx       <= '0;
      lat_addr      <= '0;
      lat_data      <= '0;
      lat_mask      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_vld) begin
        rr_ptr   <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        cmd_pend <= 1'b1;
        dat_pend <= ~req_rd[grant_idx];
        lat_rd   <= req_rd[grant_idx];
        lat_idx  <= grant_idx;
        lat_addr <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        lat_data <= req_wdata[grant_idx*DATA_W +: DATA_W];
        lat_mask <= req_wmask[grant_idx*MW +: MW];
      end else begin
        if (app_rdy)     cmd_pend <= 1'b0;
        if (app_wdf_rdy) dat_pend <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[pop_tag] <= 1'b1;
        rsp_data           <= app_rd_data;
      end
      if (app_rd_data_valid && tag_empty) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge pe_clk) begin
    if (push) tag_mem[wr_ptr[AW-1:0]] <= lat_idx;
  end

  assign app_en       = cmd_pend;
  assign app_cmd      = {2'b00, lat_rd};
  assign app_addr     = lat_addr;
  assign app_wdf_wren = dat_pend;
  assign app_wdf_end  = dat_pend;
  assign app_wdf_data = lat_data;
  assign app_wdf_mask = lat_mask;
  assign busy         = (state != ARB) || !tag_empty;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Bench for ddr_app_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ddr_app_arbiter;

  localparam int NR = 4;
  localparam int AW = 28;
  localparam int DW = 512;
  localparam int MW = DW / 8;
  localparam int TD = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             calib;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_rd;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*MW-1:0] req_wmask;
  logic             app_en;
  logic [2:0]       app_cmd;
  logic [AW-1:0]    app_addr;
  logic             app_rdy;
  logic             app_wdf_wren;
  logic             app_wdf_end;
  logic [DW-1:0]    app_wdf_data;
  logic [MW-1:0]    app_wdf_mask;
  logic             app_wdf_rdy;
  logic             app_rd_data_valid;
  logic [DW-1:0]    app_rd_data;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             busy;
  logic             err_underflow;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ddr_app_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)
  ) dut (
    .pe_clk(clk),
    .pe_clk_rst(rst),
    .init_calib_complete(calib),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd(req_rd),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .app_en(app_en),
    .app_cmd(app_cmd),
    .app_addr(app_addr),
    .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy),
    .err_underflow(err_underflow)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic cal);
    @(posedge clk);
    #1;
    rst = 1'b1;
    calib = 1'b0;
    req_valid = '0;
    req_rd = '0;
    req_addr = '0;
    req_wdata = '0;
    req_wmask = '0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    repeat (2) step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    calib = cal;
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] rd;
    logic [NR-1:0] rdy;
    logic          en;
    logic          wr;
  } vec_t;

  vec_t tbl[20];

  int m_ptr;
  bit m_iss, m_pc, m_pd, m_rd;
  int m_idx;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [MW-1:0] m_mask;
  int tagq[$];
  logic [NR-1:0] m_rsp;
  logic [DW-1:0] m_rsp_d;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bad, grants, extra, t, exp_g;
    int order[$];
    logic [AW-1:0] addrs[$];
    logic [NR-1:0] pend, exp_rdy;
    logic [DW-1:0] d0, d1;

    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[10] = '{4'b0101, 4'b0000, 4'b0100, 1'b0, 1'b0};
    tbl[11] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[12] = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 1'b0};
    tbl[13] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[15] = '{4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0};
    tbl[16] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[17] = '{4'b1110, 4'b0010, 4'b0010, 1'b0, 1'b0};
    tbl[18] = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    // reset values
    do_reset(1'b0);
    #2;
    chk("rst_app_en", DW'(app_en), '0);
    chk("rst_app_cmd", DW'(app_cmd), '0);
    chk("rst_app_addr", DW'(app_addr), '0);
    chk("rst_wren", DW'({app_wdf_wren, app_wdf_end}), '0);
    chk("rst_wdf_data", app_wdf_data, '0);
    chk("rst_wdf_mask", DW'(app_wdf_mask), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_err", DW'(err_underflow), '0);

    // calibration gate
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      req_valid = '1;
      #2;
      if (req_ready != 0 || app_en) bad++;
    end
    chk("calib_gate", DW'(bad), '0);
    step();
    calib = 1'b1;
    #2;
    chk("calib_edge_no_grant", DW'(req_ready), '0);
    step();
    #2;
    chk("calib_first_grant", DW'(req_ready), DW'(4'b0001));

    // table vectors
    do_reset(1'b1);
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      req_valid = tbl[i].v;
      req_rd = tbl[i].rd;
      #2;
      chk($sformatf("tbl%0d_ready", i), DW'(req_ready), DW'(tbl[i].rdy));
      chk($sformatf("tbl%0d_en", i), DW'(app_en), DW'(tbl[i].en));
      chk($sformatf("tbl%0d_wren", i), DW'(app_wdf_wren), DW'(tbl[i].wr));
    end
    chk("tbl_busy_tag", DW'(busy), DW'(1'b1));

    // independent command / data accept
    do_reset(1'b1);
    step();
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 28'hABCDEF0;
    req_wdata[2*DW +: DW] = {16{32'h1234_5678}};
    req_wmask[2*MW +: MW] = 64'h00FF_0000_F0F0_0001;
    #2;
    chk("wr_c1_ready", DW'(req_ready), DW'(4'b0100));
    step();
    req_valid = '0;
    #2;
    chk("wr_c2_en", DW'({app_en, app_wdf_wren, app_wdf_end}), DW'(3'b111));
    chk("wr_c2_addr", DW'(app_addr), DW'(28'hABCDEF0));
    chk("wr_c2_cmd", DW'(app_cmd), '0);
    step();
    app_rdy = 1'b1;
    #2;
    chk("wr_c3_en", DW'(app_en), DW'(1'b1));
    step();
    app_rdy = 1'b0;
    #2;
    chk("wr_c4_en", DW'({app_en, app_wdf_wren}), DW'(2'b01));
    chk("wr_c4_busy", DW'(busy), DW'(1'b1));
    step();
    #2;
    chk("wr_c5_wren", DW'(app_wdf_wren), DW'(1'b1));
    step();
    app_wdf_rdy = 1'b1;
    #2;
    chk("wr_c6_data", app_wdf_data, {16{32'h1234_5678}});
    chk("wr_c6_mask", DW'(app_wdf_mask), DW'(64'h00FF_0000_F0F0_0001));
    step();
    app_wdf_rdy = 1'b0;
    req_valid = 4'b0001;
    #2;
    chk("wr_c7_strobes", DW'({app_en, app_wdf_wren}), '0);
    chk("wr_c7_arb_grant", DW'(req_ready), DW'(4'b0001));

    // two reads, in-order returns
    do_reset(1'b1);
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    req_addr[1*AW +: AW] = 28'h100;
    req_addr[3*AW +: AW] = 28'h200;
    pend = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      step();
      req_valid = pend;
      req_rd = '1;
      #2;
      for (int i = 0; i < NR; i++)
        if (req_ready[i]) order.push_back(i);
      pend = pend & ~req_ready;
      if (app_en) addrs.push_back(app_addr);
    end
    chk("rd_grants", DW'(order.size()), DW'(2));
    chk("rd_addrs", DW'(addrs.size()), DW'(2));
    if (order.size() == 2 && addrs.size() == 2) begin
      chk("rd_order0", DW'(order[0]), DW'(1));
      chk("rd_order1", DW'(order[1]), DW'(3));
      chk("rd_addr0", DW'(addrs[0]), DW'(28'h100));
      chk("rd_addr1", DW'(addrs[1]), DW'(28'h200));
    end
    d0 = {16{32'hD0D0_0001}};
    d1 = {16{32'hD1D1_0002}};
    step();
    app_rd_data_valid = 1'b1;
    app_rd_data = d0;
    #2;
    chk("ret_lat", DW'(rsp_valid), '0);
    step();
    app_rd_data = d1;
    #2;
    chk("ret0_valid", DW'(rsp_valid), DW'(4'b0010));
    chk("ret0_data", rsp_data, d0);
    step();
    app_rd_data_valid = 1'b0;
    #2;
    chk("ret1_valid", DW'(rsp_valid), DW'(4'b1000));
    chk("ret1_data", rsp_data, d1);
    step();
    #2;
    chk("ret_done_valid", DW'(rsp_valid), '0);
    chk("ret_done_busy", DW'(busy), '0);

    // tag FIFO full
    do_reset(1'b1);
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    grants = 0;
    for (int c = 0; c < 200 && grants < TD; c++) begin
      step();
      req_valid = 4'b0001;
      req_rd = 4'b0001;
      #2;
      if (req_ready == 4'b0001) grants++;
    end
    chk("full_grants", DW'(grants), DW'(TD));
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      #2;
      if (req_ready != 0) extra++;
    end
    chk("full_33rd_held", DW'(extra), '0);
    chk("full_busy", DW'(busy), DW'(1'b1));
    step();
    req_valid = 4'b0101;
    #2;
    chk("full_write_grant", DW'(req_ready), DW'(4'b0100));
    step();
    req_valid = 4'b0001;
    #2;
    step();
    #2;
    chk("full_read_skip", DW'(req_ready), '0);
    step();
    app_rd_data_valid = 1'b1;
    app_rd_data = d0;
    #2;
    step();
    app_rd_data_valid = 1'b0;
    #2;
    chk("full_pop_rsp", DW'(rsp_valid), DW'(4'b0001));
    chk("full_regrant", DW'(req_ready), DW'(4'b0001));

    // underflow
    do_reset(1'b1);
    step();
    app_rd_data_valid = 1'b1;
    #2;
    chk("uf_before", DW'(err_underflow), '0);
    step();
    app_rd_data_valid = 1'b0;
    #2;
    chk("uf_set", DW'(err_underflow), DW'(1'b1));
    chk("uf_no_rsp", DW'(rsp_valid), '0);
    repeat (3) step();
    #2;
    chk("uf_sticky", DW'(err_underflow), DW'(1'b1));
    do_reset(1'b1);
    #2;
    chk("uf_cleared", DW'(err_underflow), '0);

    // randomized run against a transaction model
    m_ptr = 0;
    m_iss = 0;
    m_pc = 0;
    m_pd = 0;
    m_rd = 0;
    m_idx = 0;
    m_addr = '0;
    m_data = '0;
    m_mask = '0;
    tagq.delete();
    m_rsp = '0;
    m_rsp_d = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      req_valid = NR'($urandom);
      req_rd = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_addr[i*AW +: AW] = AW'($urandom);
        for (int j = 0; j < DW / 32; j++)
          req_wdata[i*DW + j*32 +: 32] = $urandom;
        req_wmask[i*MW +: MW] = {$urandom, $urandom};
      end
      app_rdy = ($urandom % 3) != 0;
      app_wdf_rdy = ($urandom % 3) != 0;
      app_rd_data_valid = (tagq.size() > 0) && (($urandom % 3) == 0);
      for (int j = 0; j < DW / 32; j++)
        app_rd_data[j*32 +: 32] = $urandom;
      #2;
      exp_g = -1;
      if (!m_iss) begin
        for (int k = 0; k < NR; k++) begin
          t = (m_ptr + k) % NR;
          if (exp_g < 0 && req_valid[t] && (!req_rd[t] || tagq.size() < TD))
            exp_g = t;
        end
      end
      exp_rdy = (exp_g >= 0) ? NR'(1 << exp_g) : '0;
      chk("rnd_ready", DW'(req_ready), DW'(exp_rdy));
      chk("rnd_en", DW'(app_en), DW'(m_iss && m_pc));
      chk("rnd_wren", DW'({app_wdf_wren, app_wdf_end}),
          DW'({2{m_iss && m_pd}}));
      if (m_iss && m_pc) begin
        chk("rnd_addr", DW'(app_addr), DW'(m_addr));
        chk("rnd_cmd", DW'(app_cmd), DW'({2'b00, m_rd}));
      end
      if (m_iss && m_pd) begin
        chk("rnd_wdata", app_wdf_data, m_data);
        chk("rnd_wmask", DW'(app_wdf_mask), DW'(m_mask));
      end
      chk("rnd_rsp_valid", DW'(rsp_valid), DW'(m_rsp));
      if (m_rsp != 0) chk("rnd_rsp_data", rsp_data, m_rsp_d);
      chk("rnd_busy", DW'(busy), DW'(m_iss || tagq.size() > 0));
      chk("rnd_err", DW'(err_underflow), '0);
      m_rsp = '0;
      if (app_rd_data_valid) begin
        t = tagq.pop_front();
        m_rsp = NR'(1 << t);
        m_rsp_d = app_rd_data;
      end
      if (m_iss) begin
        if (m_pc && app_rdy) begin
          if (m_rd) tagq.push_back(m_idx);
          m_pc = 0;
        end
        if (m_pd && app_wdf_rdy) m_pd = 0;
        if (!m_pc && !m_pd) m_iss = 0;
      end else if (exp_g >= 0) begin
        m_iss = 1;
        m_pc = 1;
        m_rd = req_rd[exp_g];
        m_pd = !m_rd;
        m_idx = exp_g;
        m_addr = req_addr[exp_g*AW +: AW];
        m_data = req_wdata[exp_g*DW +: DW];
        m_mask = req_wmask[exp_g*MW +: MW];
        m_ptr = (exp_g + 1) % NR;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
